// File: rtl/ucsbece154b_mem_arbiter_pkg.sv
// Shared types for the IF/MEM memory arbiter: FSM state encodings and grant selector.
// No logic here, only types and a width helper.
// Imported by the arbiter top.
package ucsbece154b_mem_arbiter_pkg;

   // Arbiter FSM encodings (arb_idle / arb_busy_i / arb_busy_d / arb_drain)
   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_BUSY_I = 2'b01,
      ARB_BUSY_D = 2'b10,
      ARB_DRAIN  = 2'b11
   } arb_state_e;

   // Outcome of the arbitration decision made in IDLE
   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_IF   = 2'b01,
      GNT_D    = 2'b10
   } grant_e;

   // Bits needed to hold values 0..max_val
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ucsbece154b_perf_counter.sv
// Enable-gated event counter that wraps modulo 2^DATA_W.
// Latency: count visible the cycle after the enabled cycle.
// No backpressure; clears on synchronous reset.
module ucsbece154b_perf_counter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   output logic [DATA_W-1:0] cnt_o
);

   logic [DATA_W-1:0] cnt_q, cnt_d;

   // Next count: increment when enabled, natural wrap at the top
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) cnt_d = cnt_q + 1'b1;
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Shares one single-ported variable-latency memory between fetch and data; data wins unless fetch is starved.
// Latency: grant -> registered mem request next cycle -> ready pulse the cycle after ack (3 cycles minimum).
// Requesters stall until their ready pulse; memory side holds mem_req_o until mem_ack_i. Perf counters under MEMARB_PERF_EN.
module ucsbece154b_mem_arbiter
   import ucsbece154b_mem_arbiter_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [DATA_W-1:0] if_addr_i,
   input  logic              if_abort_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [DATA_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              stall_if_o,
   output logic              stall_d_o,
   output logic [DATA_W-1:0] perf_if_grants_o,
   output logic [DATA_W-1:0] perf_d_grants_o,
   output logic [DATA_W-1:0] perf_stall_o
);

   localparam int                SW         = cnt_width(STARVE_MAX);
   localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [DATA_W-1:0] WORD_MASK  = ~DATA_W'(3);

   arb_state_e        state_q, state_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;

   grant_e            grant;
   logic              if_want, d_want, starved;

   // Arbitration: priority is decided on live requests; a requester whose ready is
   // pulsing now still holds priority but cannot be granted, so the cycle idles
   // rather than handing the slot to the other side (keeps the starvation count meaningful).
   always_comb begin
      if_want = if_req_i & ~if_abort_i;
      d_want  = d_req_i;
      starved = if_want & (starve_q == STARVE_LIM);
      grant   = GNT_NONE;
      if (state_q == ARB_IDLE) begin
         if (d_want && !starved) begin
            if (!d_ready_q) grant = GNT_D;
         end else if (if_want && !if_ready_q) begin
            grant = GNT_IF;
         end
      end
   end

   // Next-state, memory-side request registers, captured read data and ready pulses
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (!if_req_i) starve_d = '0;
            case (grant)
               GNT_D: begin
                  state_d     = ARB_BUSY_D;
                  mem_req_d   = 1'b1;
                  mem_we_d    = d_we_i;
                  mem_addr_d  = d_addr_i & WORD_MASK;
                  mem_wdata_d = d_wdata_i;
                  if (if_req_i && (starve_q != STARVE_LIM)) starve_d = starve_q + 1'b1;
               end
               GNT_IF: begin
                  state_d    = ARB_BUSY_I;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = if_addr_i & WORD_MASK;
                  starve_d   = '0;
               end
               default: ;
            endcase
         end
         ARB_BUSY_I: begin
            if (mem_ack_i) begin
               state_d   = ARB_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               // A redirect coinciding with the ack throws the instruction away
               if (!if_abort_i) begin
                  if_rdata_d = mem_rdata_i;
                  if_ready_d = 1'b1;
               end
            end else if (if_abort_i) begin
               state_d = ARB_DRAIN;
            end
         end
         ARB_BUSY_D: begin
            if (mem_ack_i) begin
               state_d   = ARB_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               d_ready_d = 1'b1;
               if (!mem_we_q) d_rdata_d = mem_rdata_i;
            end
         end
         ARB_DRAIN: begin
            // Memory cannot cancel; finish the orphaned fetch silently
            if (mem_ack_i) begin
               state_d   = ARB_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign if_ready_o  = if_ready_q;
   assign d_ready_o   = d_ready_q;

   assign stall_if_o  = if_req_i & ~if_ready_q & ~if_abort_i;
   assign stall_d_o   = d_req_i & ~d_ready_q;

`ifdef MEMARB_PERF_EN
   logic perf_if_en, perf_d_en, perf_stall_en;
   assign perf_if_en    = (grant == GNT_IF);
   assign perf_d_en     = (grant == GNT_D);
   assign perf_stall_en = stall_if_o | stall_d_o;

   ucsbece154b_perf_counter #(.DATA_W(DATA_W)) u_perf_if (
      .clk(clk), .reset(reset), .en_i(perf_if_en), .cnt_o(perf_if_grants_o));
   ucsbece154b_perf_counter #(.DATA_W(DATA_W)) u_perf_d (
      .clk(clk), .reset(reset), .en_i(perf_d_en), .cnt_o(perf_d_grants_o));
   ucsbece154b_perf_counter #(.DATA_W(DATA_W)) u_perf_stall (
      .clk(clk), .reset(reset), .en_i(perf_stall_en), .cnt_o(perf_stall_o));
`else
   assign perf_if_grants_o = '0;
   assign perf_d_grants_o  = '0;
   assign perf_stall_o     = '0;
`endif

endmodule
